// File: rtl/vga_pkg.sv
// Shared VGA timing package: FSM state encoding and 640x480@60 default timing.
package vga_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } vga_state_e;

  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFp     = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBp     = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFp     = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 33;
  localparam int unsigned DefCw      = 12;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-latency register pipeline with an asynchronous reset value; N=0 is a wire.
module vga_delay_line #(
  parameter int unsigned W = 1,
  parameter int unsigned N = 0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] rst_val_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  if (N == 0) begin : gen_pass
    logic unused_pass;
    assign unused_pass = ^{clk_i, rst_ni, rst_val_i};
    assign q_o = d_i;
  end else begin : gen_pipe
    logic [W-1:0] stage_q [N];

    // Shift every clock; reset loads the idle pattern into every stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int unsigned i = 0; i < N; i++) begin
          stage_q[i] <= rst_val_i;
        end
      end else begin
        stage_q[0] <= d_i;
        for (int unsigned i = 1; i < N; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign q_o = stage_q[N-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with run/drain control and optional output delay.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FP     = DefHFp,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BP     = DefHBp,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FP     = DefVFp,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BP     = DefVBp,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CW       = DefCw,
  parameter int unsigned PIPE_DLY = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_ce,
  input  logic          run,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start,
  output logic          frame_done,
  output logic          busy
);

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned OW    = 2 * CW + 6;

  if ((64'(H_TOT) > (64'd1 << CW)) || (64'(V_TOT) > (64'd1 << CW))) begin : gen_bad_size
    $fatal(1, "vga_timing_gen: H_TOT/V_TOT do not fit in CW bits");
  end
  if ((H_FP == 0) || (H_SYNC == 0) || (H_BP == 0) ||
      (V_FP == 0) || (V_SYNC == 0) || (V_BP == 0)) begin : gen_bad_porch
    $fatal(1, "vga_timing_gen: porch and sync widths must be non-zero");
  end
  if (PIPE_DLY > 15) begin : gen_bad_dly
    $fatal(1, "vga_timing_gen: PIPE_DLY must be 0..15");
  end

  localparam logic [CW-1:0] HLast    = CW'(H_TOT - 1);
  localparam logic [CW-1:0] VLast    = CW'(V_TOT - 1);
  localparam logic [CW-1:0] HActEnd  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VActEnd  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HSyncBeg = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HSyncEnd = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VSyncBeg = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VSyncEnd = CW'(V_ACTIVE + V_FP + V_SYNC);

  vga_state_e    state_q, state_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [CW-1:0] px_q, px_d, py_q, py_d;
  logic          de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic          ls_q, ls_d, fs_q, fs_d, fd_q, fd_d;
  logic          step, last;

  assign step = pix_ce && (state_q != StIdle);
  assign last = (x_q == HLast) && (y_q == VLast);

  // Next state: run gates scanning, a dropped run only stops at the end of a frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (run) state_d = StRun;
      end
      StRun: begin
        if (!run) state_d = (step && last) ? StIdle : StDrain;
      end
      StDrain: begin
        if (run) begin
          state_d = StRun;
        end else if (step && last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Position advance and registered outputs; the current position is presented
  // on the pix_ce cycle that moves past it, so outputs and position stay aligned.
  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    px_d = px_q;
    py_d = py_q;
    de_d = de_q;
    hs_d = hs_q;
    vs_d = vs_q;
    ls_d = 1'b0;
    fs_d = 1'b0;
    fd_d = 1'b0;
    if (state_q == StIdle) begin
      x_d  = '0;
      y_d  = '0;
      px_d = '0;
      py_d = '0;
      de_d = 1'b0;
      hs_d = ~HS_POL;
      vs_d = ~VS_POL;
    end else if (step) begin
      px_d = x_q;
      py_d = y_q;
      de_d = (x_q < HActEnd) && (y_q < VActEnd);
      hs_d = ((x_q >= HSyncBeg) && (x_q < HSyncEnd)) ? HS_POL : ~HS_POL;
      vs_d = ((y_q >= VSyncBeg) && (y_q < VSyncEnd)) ? VS_POL : ~VS_POL;
      ls_d = (x_q == '0);
      fs_d = (x_q == '0) && (y_q == '0);
      fd_d = last;
      if (x_q == HLast) begin
        x_d = '0;
        y_d = (y_q == VLast) ? '0 : y_q + CW'(1);
      end else begin
        x_d = x_q + CW'(1);
      end
    end
  end

  // State, position and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      px_q    <= '0;
      py_q    <= '0;
      de_q    <= 1'b0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      px_q    <= px_d;
      py_q    <= py_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      fd_q    <= fd_d;
    end
  end

  logic [OW-1:0] pre_w, post_w, idle_w;

  assign pre_w  = {de_q, hs_q, vs_q, ls_q, fs_q, fd_q, px_q, py_q};
  assign idle_w = {1'b0, ~HS_POL, ~VS_POL, 3'b000, {CW{1'b0}}, {CW{1'b0}}};

  vga_delay_line #(
    .W(OW),
    .N(PIPE_DLY)
  ) u_dly (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .rst_val_i(idle_w),
    .d_i      (pre_w),
    .q_o      (post_w)
  );

  assign {de, hsync, vsync, line_start, frame_start, frame_done, pixel_x, pixel_y} = post_w;
  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: two small-geometry DUTs (direct and 3-stage delayed, inverted
// polarity) on randomized run/pix_ce, plus two default-geometry DUTs free-running.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Group A: 4/1/2/1 x 3/1/1/1 geometry.
  logic        rst_n_a, run_a, ce_a;
  logic        hs_a, vs_a, de_a, ls_a, fs_a, fd_a, busy_a;
  logic [11:0] px_a, py_a;
  logic        hs_b, vs_b, de_b, ls_b, fs_b, fd_b, busy_b;
  logic [11:0] px_b, py_b;
  // Group C: default 640x480 geometry.
  logic        rst_n_c, run_c, ce_c;
  logic        hs_c, vs_c, de_c, ls_c, fs_c, fd_c, busy_c;
  logic [11:0] px_c, py_c;
  logic        hs_d, vs_d, de_d, ls_d, fs_d, fd_d, busy_d;
  logic [11:0] px_d, py_d;

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n_a), .pix_ce(ce_a), .run(run_a), .hsync(hs_a), .vsync(vs_a),
    .de(de_a), .pixel_x(px_a), .pixel_y(py_a), .line_start(ls_a), .frame_start(fs_a),
    .frame_done(fd_a), .busy(busy_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(3)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n_a), .pix_ce(ce_a), .run(run_a), .hsync(hs_b), .vsync(vs_b),
    .de(de_b), .pixel_x(px_b), .pixel_y(py_b), .line_start(ls_b), .frame_start(fs_b),
    .frame_done(fd_b), .busy(busy_b)
  );

  vga_timing_gen u_dut_c (
    .clk(clk), .rst_n(rst_n_c), .pix_ce(ce_c), .run(run_c), .hsync(hs_c), .vsync(vs_c),
    .de(de_c), .pixel_x(px_c), .pixel_y(py_c), .line_start(ls_c), .frame_start(fs_c),
    .frame_done(fd_c), .busy(busy_c)
  );

  vga_timing_gen #(
    .HS_POL(1'b1), .PIPE_DLY(3)
  ) u_dut_d (
    .clk(clk), .rst_n(rst_n_c), .pix_ce(ce_c), .run(run_c), .hsync(hs_d), .vsync(vs_d),
    .de(de_d), .pixel_x(px_d), .pixel_y(py_d), .line_start(ls_d), .frame_start(fs_d),
    .frame_done(fd_d), .busy(busy_d)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int ht; int vt; int ha; int hfp; int hsw; int va; int vfp; int vsw;
  } geom_t;

  typedef struct {
    int x; int y; bit de; bit hact; bit vact; bit ls; bit fs; bit fd;
  } pres_t;

  geom_t geo    [2];
  bit    m_on   [2];
  int    m_pos  [2];
  int    m_de   [2];
  pres_t m_hist [2][4];  // [0] = presented now, [3] = presented three clocks ago

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int de_cnt_c = 0;

  function automatic pres_t pres_idle();
    pres_t r;
    r = '{default: 0};
    return r;
  endfunction

  function automatic pres_t pres_at(geom_t g, int p);
    pres_t r;
    r.x    = p % g.ht;
    r.y    = p / g.ht;
    r.de   = (r.x < g.ha) && (r.y < g.va);
    r.hact = (r.x >= g.ha + g.hfp) && (r.x < g.ha + g.hfp + g.hsw);
    r.vact = (r.y >= g.va + g.vfp) && (r.y < g.va + g.vfp + g.vsw);
    r.ls   = (r.x == 0);
    r.fs   = (p == 0);
    r.fd   = (p == g.ht * g.vt - 1);
    return r;
  endfunction

  task automatic model_reset(input int gi);
    m_on[gi]  = 1'b0;
    m_pos[gi] = 0;
    for (int k = 0; k < 4; k++) m_hist[gi][k] = pres_idle();
  endtask

  // One clock edge of the reference: scanning continues while busy; a frame ends
  // (going idle) only on the last pixel's pix_ce with run low.
  task automatic model_edge(input int gi, input logic rst, input logic r, input logic ce);
    pres_t cur;
    bit    lastp;
    if (!rst) begin
      model_reset(gi);
      return;
    end
    cur    = m_hist[gi][0];
    cur.ls = 1'b0;
    cur.fs = 1'b0;
    cur.fd = 1'b0;
    if (!m_on[gi]) begin
      cur       = pres_idle();
      m_pos[gi] = 0;
      if (r) m_on[gi] = 1'b1;
    end else if (ce) begin
      cur       = pres_at(geo[gi], m_pos[gi]);
      lastp     = (m_pos[gi] == geo[gi].ht * geo[gi].vt - 1);
      m_pos[gi] = lastp ? 0 : m_pos[gi] + 1;
      if (lastp && !r) m_on[gi] = 1'b0;
    end
    for (int k = 3; k > 0; k--) m_hist[gi][k] = m_hist[gi][k-1];
    m_hist[gi][0] = cur;
    if (cur.de) m_de[gi]++;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_grp(input int gi, input string nm, input int lag, input bit hpol,
                           input bit vpol, input logic [11:0] px, input logic [11:0] py,
                           input logic de, input logic hs, input logic vs, input logic ls,
                           input logic fs, input logic fd, input logic bsy);
    pres_t e;
    e = m_hist[gi][lag];
    chk({nm, "_x"},    32'(px),  32'(e.x));
    chk({nm, "_y"},    32'(py),  32'(e.y));
    chk({nm, "_de"},   32'(de),  32'(e.de));
    chk({nm, "_hs"},   32'(hs),  32'(e.hact ? hpol : !hpol));
    chk({nm, "_vs"},   32'(vs),  32'(e.vact ? vpol : !vpol));
    chk({nm, "_ls"},   32'(ls),  32'(e.ls));
    chk({nm, "_fs"},   32'(fs),  32'(e.fs));
    chk({nm, "_fd"},   32'(fd),  32'(e.fd));
    chk({nm, "_busy"}, 32'(bsy), 32'(m_on[gi]));
  endtask

  task automatic check_all();
    check_grp(0, "a", 0, 1'b0, 1'b0, px_a, py_a, de_a, hs_a, vs_a, ls_a, fs_a, fd_a, busy_a);
    check_grp(0, "b", 3, 1'b1, 1'b1, px_b, py_b, de_b, hs_b, vs_b, ls_b, fs_b, fd_b, busy_b);
    check_grp(1, "c", 0, 1'b0, 1'b0, px_c, py_c, de_c, hs_c, vs_c, ls_c, fs_c, fd_c, busy_c);
    check_grp(1, "d", 3, 1'b1, 1'b0, px_d, py_d, de_d, hs_d, vs_d, ls_d, fs_d, fd_d, busy_d);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge(0, rst_n_a, run_a, ce_a);
    model_edge(1, rst_n_c, run_c, ce_c);
    #1;
    if (de_c) de_cnt_c++;
    check_all();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int  last_fd;
    bit  seen_fd;
    geo[0] = '{ht: 8,   vt: 6,   ha: 4,   hfp: 1,  hsw: 2,  va: 3,   vfp: 1,  vsw: 1};
    geo[1] = '{ht: 800, vt: 525, ha: 640, hfp: 16, hsw: 96, va: 480, vfp: 10, vsw: 2};
    m_de[0] = 0;
    m_de[1] = 0;
    rst_n_a = 1'b1; rst_n_c = 1'b1;
    run_a = 1'b0; ce_a = 1'b0; run_c = 1'b0; ce_c = 1'b0;

    // Reset state.
    #1;
    rst_n_a = 1'b0;
    rst_n_c = 1'b0;
    model_reset(0);
    model_reset(1);
    #1;
    check_all();

    // Default geometry free-runs from here on with run=1, pix_ce=1.
    rst_n_c = 1'b1;
    run_c   = 1'b1;
    ce_c    = 1'b1;
    step();
    step();
    rst_n_a = 1'b1;
    step();

    // Small geometry, pix_ce every other clock: frame_done period 2*48 clocks.
    run_a   = 1'b1;
    last_fd = -1;
    for (int i = 0; i < 300; i++) begin
      ce_a = ~ce_a;
      step();
      if (fd_a) begin
        if (last_fd >= 0) chk("a_fd_period", 32'(cyc - last_fd), 32'd96);
        last_fd = cyc;
      end
    end

    // Randomized run / pix_ce.
    for (int i = 0; i < 400; i++) begin
      ce_a = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) run_a = ~run_a;
      step();
    end

    // Drop run mid-frame at (2,3): frame must finish with frame_done, then idle.
    run_a = 1'b1;
    ce_a  = 1'b1;
    for (int i = 0; i < 120 && !(m_on[0] && m_pos[0] == 26); i++) step();
    run_a   = 1'b0;
    seen_fd = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (fd_a) seen_fd = 1'b1;
    end
    chk("a_drain_fd_seen", 32'(seen_fd), 32'd1);
    chk("a_drain_busy", 32'(busy_a), 32'd0);
    chk("a_drain_de", 32'(de_a), 32'd0);
    chk("a_drain_px", 32'(px_a), 32'd0);

    // Re-raise run while draining: scanning continues without a jump.
    run_a = 1'b1;
    repeat (20) step();
    run_a = 1'b0;
    repeat (3) step();
    chk("a_drain_busy_mid", 32'(busy_a), 32'd1);
    run_a = 1'b1;
    repeat (60) step();

    // Reset mid-frame: outputs idle immediately, restart at (0,0) with frame_start.
    for (int i = 0; i < 60 && m_pos[0] != 20; i++) step();
    rst_n_a = 1'b0;
    #1;
    model_reset(0);
    check_all();
    chk("a_rst_busy", 32'(busy_a), 32'd0);
    step();
    step();
    rst_n_a = 1'b1;
    step();
    step();
    chk("a_restart_fs", 32'(fs_a), 32'd1);
    chk("a_restart_x", 32'(px_a), 32'd0);
    chk("a_restart_y", 32'(py_a), 32'd0);

    // Fill out the run so the default geometry covers several full lines.
    while (cyc < 2700) begin
      ce_a  = 1'($urandom_range(0, 1));
      run_a = ($urandom_range(0, 9) != 0);
      step();
    end
    chk("c_de_count", 32'(de_cnt_c), 32'(m_de[1]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have these parameters, one per line: name, default, meaning.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, horizontal sync width.
- H_BP, 48, horizontal back porch.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vertical sync width.
- V_BP, 33, vertical back porch.
- HS_POL, 0, hsync active level.
- VS_POL, 0, vsync active level.
- CW, 12, counter/coordinate width.
- PIPE_DLY, 0, extra output delay stages (0..15).

REQ-002 SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, pixel clock.
- rst_n, in, 1, asynchronous active-low reset.
- pix_ce, in, 1, pixel advance enable.
- run, in, 1, start/continue scanning.
- hsync, out, 1, horizontal sync.
- vsync, out, 1, vertical sync.
- de, out, 1, display enable.
- pixel_x, out, CW, current column.
- pixel_y, out, CW, current line.
- line_start, out, 1, pulse at x==0.
- frame_start, out, 1, pulse at (0,0).
- frame_done, out, 1, pulse on last pixel of frame.
- busy, out, 1, state != IDLE.

REQ-003 SHALL use one clock, clk; reset rst_n is asynchronous, active-low.

Function
REQ-004 SHALL define H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOT = V_ACTIVE+V_FP+V_SYNC+V_BP; elaboration SHALL fail if H_TOT or V_TOT > 2^CW, or if any porch/sync parameter is 0.
REQ-005 SHALL implement FSM IDLE, RUN, DRAIN.
- IDLE->RUN when run=1.
- RUN->DRAIN when run=0.
- DRAIN->RUN when run=1.
- DRAIN->IDLE after the pix_ce cycle at (H_TOT-1, V_TOT-1).
- RUN->IDLE directly when run=0 coincides with that last-pixel pix_ce.
REQ-006 SHALL hold the position in IDLE at (0,0); on entering RUN from IDLE the first presented position SHALL be (0,0).
REQ-007 SHALL advance the position only on cycles with pix_ce=1 in RUN or DRAIN; with pix_ce=0 all outputs SHALL hold, and pulses SHALL last exactly one clk cycle.
REQ-008 x SHALL wrap H_TOT-1->0 and increment y; y SHALL wrap V_TOT-1->0 on the same cycle x wraps.
REQ-009 Outputs SHALL be registered and mutually aligned: pixel_x/pixel_y equal the position; de=1 iff x<H_ACTIVE and y<V_ACTIVE; hsync=HS_POL iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, else !HS_POL; vsync likewise for y with V parameters and VS_POL.
REQ-010 line_start SHALL assert the first cycle each new x==0 is presented; frame_start when (0,0) is presented; frame_done when (H_TOT-1, V_TOT-1) is presented.
REQ-011 With PIPE_DLY=N>0, hsync, vsync, de, pixel_x, pixel_y, line_start, frame_start and frame_done SHALL all be delayed by exactly N clk cycles (not pix_ce-gated); busy is undelayed.
REQ-012 In IDLE the presented outputs SHALL be de=0 and syncs inactive, after the pipeline drains.

Reset
REQ-013 rst_n=0 SHALL immediately force: state IDLE, position (0,0), de=0, hsync=!HS_POL, vsync=!VS_POL, pixel_x=pixel_y=0, all pulses 0, busy=0, and all delay stages cleared to the same idle values.
REQ-014 Reset mid-frame SHALL abort the frame with no frame_done; after release with run=1 the next frame SHALL start at (0,0).

Structure
REQ-015 A shared package vga_pkg SHALL hold the FSM state encoding and the default 640x480@60 timing constants.
REQ-016 Delay pipeline SHALL be sub-module vga_delay_line (width W, depth N, async reset value input, N=0 pass-through).

Verification
REQ-017 Defaults, run=1, pix_ce=1: hsync=0 exactly for x 656..751; vsync=0 exactly for y 490..491; 307200 de cycles; frame_done every 420000 cycles.
REQ-018 Params 4/1/2/1, 3/1/1/1, pix_ce every other clk: H_TOT=8, V_TOT=6; frame_done every 96 clk; each value held 2 clk.
REQ-019 run dropped at (100,200): frame completes to (799,524), then IDLE, busy=0; run re-raised at (5,5) in DRAIN: no discontinuity.
REQ-020 rst_n pulsed at (300,100): outputs idle immediately, no frame_done; restart at (0,0) with frame_start.
REQ-021 PIPE_DLY=3, HS_POL=1: all delayed outputs lag PIPE_DLY=0 reference by 3 clk; hsync high for x 656..751.
